// File: rtl/sram_64x64_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sram_64x64_ctrl
//  Purpose  : Valid/ready front end for a 64 x 64-bit single-port SRAM.
//             Requests are forwarded to the SRAM combinationally in the cycle
//             they are accepted.  Reads return their data through a 2-entry
//             response FIFO.  A credit check on the request side keeps that
//             FIFO from ever overflowing.
//  Ports    :
//    i_clk, i_rst_n          clock; asynchronous active-low reset
//    i_req_valid/o_req_ready request handshake
//    i_req_we                1 = write, 0 = read
//    i_req_addr[5:0]         word address
//    i_req_wdata[63:0]       write data
//    i_req_be[7:0]           byte enables, bit k covers data bits [8k+7:8k]
//    o_rsp_valid/i_rsp_ready read response handshake
//    o_rsp_rdata[63:0]       read data (FIFO head)
//    o_sram_*                SRAM macro control, address, data and bit mask
//    i_sram_rdata[63:0]      SRAM read data, valid one cycle after the access
//    o_busy                  a read is in flight or the FIFO holds data
//  Revision : 1.0 - initial release
// ============================================================================
module sram_64x64_ctrl (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [5:0]  i_req_addr,
    input  logic [63:0] i_req_wdata,
    input  logic [7:0]  i_req_be,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [63:0] o_rsp_rdata,
    output logic        o_sram_cen,
    output logic        o_sram_wen,
    output logic [5:0]  o_sram_addr,
    output logic [63:0] o_sram_wdata,
    output logic [63:0] o_sram_bit_mask,
    input  logic [63:0] i_sram_rdata,
    output logic        o_busy
);

    logic        w_acc;
    logic        w_pop;
    logic        w_push;
    logic [2:0]  w_outstanding;

    logic        rd_pend_q;
    logic        rd_pend_d;
    logic [63:0] fifo_q [2];
    logic        wr_ptr_q;
    logic        rd_ptr_q;
    logic [1:0]  cnt_q;
    logic [1:0]  cnt_d;

    // ------------------------------------------------------------------
    // Handshakes and credit
    // ------------------------------------------------------------------
    assign w_pop = o_rsp_valid & i_rsp_ready;

    // Every read still owed to the consumer occupies either the pending
    // slot or a FIFO entry, so their sum is the number of credits in use.
    // A pop in this cycle frees one entry at the same edge, which is what
    // lets a blocked requester go the moment the consumer takes data.
    assign w_outstanding = {1'b0, cnt_q} + {2'b00, rd_pend_q};
    assign o_req_ready   = i_rst_n & ((w_outstanding < 3'd2) | w_pop);
    assign w_acc         = i_req_valid & o_req_ready;

    // ------------------------------------------------------------------
    // SRAM side: purely combinational from the accepted request
    // ------------------------------------------------------------------
    assign o_sram_cen   = w_acc;
    assign o_sram_wen   = w_acc & i_req_we;
    assign o_sram_addr  = i_req_addr;
    assign o_sram_wdata = i_req_wdata;

    generate
        for (genvar k = 0; k < 8; k++) begin : g_mask
            assign o_sram_bit_mask[8*k +: 8] = {8{o_sram_wen & i_req_be[k]}};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read tracking and response FIFO
    // ------------------------------------------------------------------
    assign rd_pend_d = w_acc & ~i_req_we;

    // SRAM data for the read accepted last cycle is on i_sram_rdata now.
    assign w_push = rd_pend_q;

    always_comb begin
        cnt_d = cnt_q;
        case ({w_push, w_pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage is cleared by reset as well so that o_rsp_rdata reads zero
    // while the block is held in reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_pend_q <= 1'b0;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            cnt_q     <= 2'd0;
        end else begin
            rd_pend_q <= rd_pend_d;
            if (w_push) begin
                fifo_q[wr_ptr_q] <= i_sram_rdata;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (w_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_d;
        end
    end

    assign o_rsp_valid = (cnt_q != 2'd0);
    assign o_rsp_rdata = fifo_q[rd_ptr_q];
    assign o_busy      = rd_pend_q | o_rsp_valid;

endmodule
`default_nettype wire

// File: tb/tb_sram_64x64_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_64x64_ctrl
//  Purpose  : Self-checking bench for sram_64x64_ctrl.  A behavioural SRAM
//             macro sits on the SRAM port.  A reference model tracks the
//             memory contents and the queue of owed read responses, and is
//             compared with the DUT on every falling clock edge.  Directed
//             scenarios add literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sram_64x64_ctrl;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_we;
    logic [5:0]  i_req_addr;
    logic [63:0] i_req_wdata;
    logic [7:0]  i_req_be;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [63:0] o_rsp_rdata;
    logic        o_sram_cen;
    logic        o_sram_wen;
    logic [5:0]  o_sram_addr;
    logic [63:0] o_sram_wdata;
    logic [63:0] o_sram_bit_mask;
    logic [63:0] i_sram_rdata;
    logic        o_busy;

    sram_64x64_ctrl dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_req_valid     (i_req_valid),
        .o_req_ready     (o_req_ready),
        .i_req_we        (i_req_we),
        .i_req_addr      (i_req_addr),
        .i_req_wdata     (i_req_wdata),
        .i_req_be        (i_req_be),
        .o_rsp_valid     (o_rsp_valid),
        .i_rsp_ready     (i_rsp_ready),
        .o_rsp_rdata     (o_rsp_rdata),
        .o_sram_cen      (o_sram_cen),
        .o_sram_wen      (o_sram_wen),
        .o_sram_addr     (o_sram_addr),
        .o_sram_wdata    (o_sram_wdata),
        .o_sram_bit_mask (o_sram_bit_mask),
        .i_sram_rdata    (i_sram_rdata),
        .o_busy          (o_busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural SRAM macro: read data appears one cycle after the access
    // ------------------------------------------------------------------
    logic [63:0] sram_mem [64];
    always @(posedge i_clk) begin
        if (o_sram_cen) begin
            if (o_sram_wen)
                sram_mem[o_sram_addr] <= (sram_mem[o_sram_addr] & ~o_sram_bit_mask)
                                       | (o_sram_wdata & o_sram_bit_mask);
            else
                i_sram_rdata <= sram_mem[o_sram_addr];
        end
    end

    // ------------------------------------------------------------------
    // Reference model: golden memory plus queue of owed responses, each
    // tagged with the first cycle it may be presented (accept cycle + 2).
    // ------------------------------------------------------------------
    typedef struct {
        logic [63:0] data;
        int          ready_cyc;
    } rsp_t;

    logic [63:0] gmem [64];
    rsp_t        rq [$];

    logic        m_valid, m_pop, m_ready, m_acc;
    logic [63:0] m_data, m_mask;

    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            chk("rst_req_ready", {63'd0, o_req_ready}, 64'd0);
            chk("rst_rsp_valid", {63'd0, o_rsp_valid}, 64'd0);
            chk("rst_rsp_rdata", o_rsp_rdata, 64'd0);
            chk("rst_sram_cen",  {63'd0, o_sram_cen}, 64'd0);
            chk("rst_sram_wen",  {63'd0, o_sram_wen}, 64'd0);
            chk("rst_bit_mask",  o_sram_bit_mask, 64'd0);
            chk("rst_busy",      {63'd0, o_busy}, 64'd0);
            rq.delete();
        end else begin
            m_valid = (rq.size() > 0) && (rq[0].ready_cyc <= cyc);
            m_data  = m_valid ? rq[0].data : 64'd0;
            m_pop   = m_valid & i_rsp_ready;
            m_ready = (rq.size() < 2) | m_pop;
            m_acc   = i_req_valid & m_ready;
            for (int k = 0; k < 8; k++)
                m_mask[8*k +: 8] = (m_acc && i_req_we && i_req_be[k]) ? 8'hFF : 8'h00;

            chk("req_ready", {63'd0, o_req_ready}, {63'd0, m_ready});
            chk("rsp_valid", {63'd0, o_rsp_valid}, {63'd0, m_valid});
            chk("busy",      {63'd0, o_busy},      {63'd0, (rq.size() != 0)});
            chk("sram_cen",  {63'd0, o_sram_cen},  {63'd0, m_acc});
            chk("sram_wen",  {63'd0, o_sram_wen},  {63'd0, m_acc & i_req_we});
            chk("bit_mask",  o_sram_bit_mask, m_mask);
            if (m_valid)
                chk("rsp_rdata", o_rsp_rdata, m_data);
            if (m_acc) begin
                chk("sram_addr",  {58'd0, o_sram_addr}, {58'd0, i_req_addr});
                chk("sram_wdata", o_sram_wdata, i_req_wdata);
            end

            if (m_pop)
                void'(rq.pop_front());
            if (m_acc) begin
                if (i_req_we)
                    gmem[i_req_addr] = (gmem[i_req_addr] & ~m_mask) | (i_req_wdata & m_mask);
                else
                    rq.push_back('{data: gmem[i_req_addr], ready_cyc: cyc + 2});
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    int          acc_cyc;
    int          first_acc;
    int          start_cyc;
    logic [63:0] last_mask;

    // Present one request (called just after a rising edge) and hold it
    // until accepted.  Returns just after the edge that ends the accept
    // cycle, with i_req_valid dropped.
    task automatic issue(input logic we, input logic [5:0] a,
                         input logic [63:0] d, input logic [7:0] be);
        bit done = 1'b0;
        i_req_valid = 1'b1;
        i_req_we    = we;
        i_req_addr  = a;
        i_req_wdata = d;
        i_req_be    = be;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge i_clk);
            if (o_req_ready) begin
                acc_cyc   = cyc;
                last_mask = o_sram_bit_mask;
                done      = 1'b1;
            end
            @(posedge i_clk);
            #1;
        end
        if (!done)
            chk("issue_timeout", 64'd0, 64'd1);
        i_req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            sram_mem[i] = 64'h0101_0101_0101_0101 * i;
            gmem[i]     = 64'h0101_0101_0101_0101 * i;
        end
        i_sram_rdata = '0;
        i_req_valid  = 1'b0;
        i_req_we     = 1'b0;
        i_req_addr   = '0;
        i_req_wdata  = '0;
        i_req_be     = '0;
        i_rsp_ready  = 1'b1;
        i_rst_n      = 1'b1;
        #2 i_rst_n   = 1'b0;
        idle(3);
        i_rst_n = 1'b1;

        // Full write then read back of address 5
        issue(1'b1, 6'd5, 64'h0123_4567_89AB_CDEF, 8'hFF);
        chk("w5_mask", last_mask, 64'hFFFF_FFFF_FFFF_FFFF);
        issue(1'b0, 6'd5, 64'd0, 8'h00);
        @(negedge i_clk);
        chk("r5_valid_n1", {63'd0, o_rsp_valid}, 64'd0);
        @(negedge i_clk);
        chk("r5_valid_n2", {63'd0, o_rsp_valid}, 64'd1);
        chk("r5_data",     o_rsp_rdata, 64'h0123_4567_89AB_CDEF);
        idle(2);

        // Partial write: lower four bytes of an all-ones word cleared
        issue(1'b1, 6'd9, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        issue(1'b1, 6'd9, 64'd0, 8'h0F);
        chk("w9_mask", last_mask, 64'h0000_0000_FFFF_FFFF);
        issue(1'b0, 6'd9, 64'd0, 8'h00);
        @(negedge i_clk);
        @(negedge i_clk);
        chk("r9_data", o_rsp_rdata, 64'hFFFF_FFFF_0000_0000);
        idle(2);

        // Zero byte-enable write touches nothing
        issue(1'b1, 6'd3, 64'hDEAD_BEEF_DEAD_BEEF, 8'h00);
        chk("w3_mask", last_mask, 64'd0);
        issue(1'b0, 6'd3, 64'd0, 8'h00);
        @(negedge i_clk);
        @(negedge i_clk);
        chk("r3_data", o_rsp_rdata, 64'h0303_0303_0303_0303);
        idle(2);

        // Back-pressure: two reads fit, the third waits for the first pop
        i_rsp_ready = 1'b0;
        issue(1'b0, 6'd17, 64'd0, 8'h00);
        issue(1'b0, 6'd34, 64'd0, 8'h00);
        i_req_valid = 1'b1;
        i_req_we    = 1'b0;
        i_req_addr  = 6'd51;
        @(negedge i_clk);
        chk("bp_ready_blocked1", {63'd0, o_req_ready}, 64'd0);
        @(posedge i_clk); #1;
        @(negedge i_clk);
        chk("bp_ready_blocked2", {63'd0, o_req_ready}, 64'd0);
        chk("bp_head_data", o_rsp_rdata, 64'h1111_1111_1111_1111);
        @(posedge i_clk); #1;
        i_rsp_ready = 1'b1;
        @(negedge i_clk);
        chk("bp_ready_on_pop", {63'd0, o_req_ready}, 64'd1);
        chk("bp_pop_data", o_rsp_rdata, 64'h1111_1111_1111_1111);
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        @(negedge i_clk);
        chk("bp_second_data", o_rsp_rdata, 64'h2222_2222_2222_2222);
        idle(5);

        // Streaming reads with the consumer always ready
        for (int a = 0; a < 8; a++) begin
            issue(1'b0, a[5:0], 64'd0, 8'h00);
            if (a == 0) first_acc = acc_cyc;
        end
        chk("stream_accepts", 64'(acc_cyc - first_acc), 64'd7);
        @(negedge i_clk);
        chk("stream_busy_n1", {63'd0, o_busy}, 64'd1);
        @(negedge i_clk);
        chk("stream_busy_n2", {63'd0, o_busy}, 64'd1);
        @(negedge i_clk);
        chk("stream_busy_n3", {63'd0, o_busy}, 64'd0);
        idle(2);

        // Reset with one read pending and one FIFO entry
        i_rsp_ready = 1'b0;
        issue(1'b0, 6'd17, 64'd0, 8'h00);
        issue(1'b0, 6'd34, 64'd0, 8'h00);
        chk("pre_rst_valid", {63'd0, o_rsp_valid}, 64'd1);
        chk("pre_rst_busy",  {63'd0, o_busy}, 64'd1);
        i_rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {63'd0, o_rsp_valid}, 64'd0);
        chk("async_rst_rdata", o_rsp_rdata, 64'd0);
        chk("async_rst_busy",  {63'd0, o_busy}, 64'd0);
        chk("async_rst_ready", {63'd0, o_req_ready}, 64'd0);
        idle(2);
        i_rsp_ready = 1'b1;
        i_rst_n     = 1'b1;
        start_cyc   = cyc;
        issue(1'b0, 6'd51, 64'd0, 8'h00);
        chk("post_rst_first_accept", 64'(acc_cyc - start_cyc), 64'd0);
        @(negedge i_clk);
        chk("post_rst_valid_n1", {63'd0, o_rsp_valid}, 64'd0);
        @(negedge i_clk);
        chk("post_rst_valid_n2", {63'd0, o_rsp_valid}, 64'd1);
        chk("post_rst_data", o_rsp_rdata, 64'h3333_3333_3333_3333);
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
